// File: rtl/hilo_muldiv_unit.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// MULT/MULTU complete in the issue cycle; DIV/DIVU run a restoring divider and stall the pipeline.
module hilo_muldiv_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        flush,
    input  logic [7:0]  alucontrol,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stall,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int DATA_W = 32;

    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t state, state_n;
    logic [5:0] count;

    logic go;
    logic is_div;
    logic is_sdiv;
    logic div_issue;
    logic b_zero;

    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dsr;
    logic              q_neg;
    logic              r_neg;

    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   diff;
    logic              q_bit;
    logic [DATA_W-1:0] rem_nxt;

    logic signed [2*DATA_W-1:0] prod_s;
    logic        [2*DATA_W-1:0] prod_u;

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                     input logic neg);
        return neg ? -v : v;
    endfunction

    assign go        = start & ~flush;
    assign is_sdiv   = (alucontrol == EXE_DIV_OP);
    assign is_div    = is_sdiv | (alucontrol == EXE_DIVU_OP);
    assign div_issue = go & is_div;
    assign b_zero    = (b == '0);

    // Issue cycle asserts stall so the divide stays in EX while iterating
    assign stall = resetn & (((state == IDLE) & div_issue) | ((state == DIV) & ~flush));

    always_comb begin
        result = '0;
        if (go) begin
            if (alucontrol == EXE_MFHI_OP) begin
                result = hi;
            end else if (alucontrol == EXE_MFLO_OP) begin
                result = lo;
            end
        end
    end

    assign prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    always_comb begin
        rem_sh  = {rem, dvd[DATA_W-1]};
        diff    = rem_sh - {1'b0, dsr};
        q_bit   = ~diff[DATA_W];
        rem_nxt = q_bit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (div_issue) state_n = DIV;
            DIV: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (count == LAST_STEP) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                count <= '0;
            end else if (state == DIV) begin
                count <= count + 6'd1;
            end
        end
    end

    // Divider datapath; a zero divisor keeps the raw dividend so hi returns a unmodified
    always_ff @(posedge clk) begin
        if ((state == IDLE) && div_issue) begin
            rem   <= '0;
            dvd   <= (is_sdiv && !b_zero) ? magnitude($signed(a)) : a;
            dsr   <= is_sdiv ? magnitude($signed(b)) : b;
            q_neg <= is_sdiv & ~b_zero & (a[DATA_W-1] ^ b[DATA_W-1]);
            r_neg <= is_sdiv & ~b_zero & a[DATA_W-1];
        end else if (state == DIV) begin
            rem <= rem_nxt;
            dvd <= {dvd[DATA_W-2:0], q_bit};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (state == DONE) begin
            if (!flush) begin
                lo <= apply_sign(dvd, q_neg);
                hi <= apply_sign(rem, r_neg);
            end
        end else if ((state == IDLE) && go) begin
            case (alucontrol)
                EXE_MULT_OP:  {hi, lo} <= prod_s;
                EXE_MULTU_OP: {hi, lo} <= prod_u;
                EXE_MTHI_OP:  hi <= a;
                EXE_MTLO_OP:  lo <= a;
                default: ;
            endcase
        end
    end

endmodule
